e_mdu: RTL
==========

# e_mdu

Execute-stage multiply/divide sequencer for the five-stage pipelined MIPS core. It sits beside the E-stage ALU and accepts one mult/multu/div/divu/mthi/mtlo/mfhi/mflo operation per cycle from the E-stage control bundle. It owns the architectural HI/LO registers and enforces fixed multi-cycle latency with a down-counter. It reports `busy` so the hazard unit can stall later HI/LO-dependent instructions in D.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for mult/multu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).

Ports:
- `clk` input 1: single clock, rising-edge.
- `reset` input 1: synchronous, active-high; clears all state.
- `start` input 1: E-stage instruction is an MD operation this cycle (one-cycle pulse from decode).
- `mdOp` input 4: operation code from the shared def file.
- `srcA` input 32: rs operand (forwarded).
- `srcB` input 32: rt operand (forwarded).
- `busy` output 1: registered; high while a mult/div is in flight.
- `hi` output 32: architectural HI.
- `lo` output 32: architectural LO.
- `mdResult` output 32: combinational; `hi` for mfhi, `lo` for mflo, 0 otherwise.

## Operation
- States: IDLE (busy=0, cnt=0), RUN (busy=1, cnt>0).
- IDLE, edge with `start`=1:
  - mult/multu: capture {hi,lo} result of signed/unsigned 32×32→64 into pending regs, cnt←MULT_CYCLES, busy←1.
  - div/divu: pending lo←quotient, hi←remainder (signed truncates toward zero, remainder takes sign of dividend), cnt←DIV_CYCLES, busy←1.
  - mthi: hi←srcA. mtlo: lo←srcA. Immediate, no busy.
  - mfhi/mflo/none: no state change.
- RUN, each edge: cnt←cnt−1. On the edge where cnt==1: hi/lo←pending, busy←0, return to IDLE.
- Divide by zero (srcB==0, div or divu): busy sequence runs normally; hi/lo unchanged at completion.
- Signed div 0x80000000 / −1: lo=0x80000000, hi=0.
- `start` while busy: ignored entirely, including mthi/mtlo. The hazard unit prevents this; the block must not corrupt state if it occurs.
- mfhi/mflo during RUN return the old hi/lo. The hazard unit stalls these, so no forwarding of pending results.
- `reset`: hi, lo, pending, cnt ← 0; busy ← 0. Takes priority over `start` and aborts RUN mid-operation with no HI/LO commit.

## Timing
- Reset values: busy=0, hi=0, lo=0, mdResult=0.
- `start` sampled at edge T. busy is high for cycles T+1 … T+N, where N is MULT_CYCLES or DIV_CYCLES. New hi/lo are visible from cycle T+N+1, the same cycle busy first reads 0.
- A new `start` is accepted in the first cycle busy reads 0 (back-to-back, no bubble).
- mthi/mtlo at edge T: value visible on hi/lo from cycle T+1.
- mdResult has zero latency from mdOp/hi/lo. Stall condition for hazard unit = `start | busy` (formed outside this block).

## Structure
- Shared def file: `mdOp_none, mdOp_mult, mdOp_multu, mdOp_div, mdOp_divu, mdOp_mthi, mdOp_mtlo, mdOp_mfhi, mdOp_mflo` (4-bit), alongside the existing aluOp defines.
- One sub-module `e_md_calc`: purely combinational 64-bit product and quotient/remainder generation with a signed/unsigned select.
- `e_mdu` holds the counter, the pending and HI/LO registers, and the op decode.

## Test plan
- Reset, then mult srcA=0xFFFFFFFF, srcB=2 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles. Sampling hi mid-run shows the old value.
- div srcA=0xFFFFFFF9 (−7), srcB=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> hi/lo unchanged after 10 cycles.
- mthi 0x12345678, next cycle mfhi -> mdResult=0x12345678. mtlo pulsed during a div run -> ignored; lo equals the div result at completion.
- Back-to-back: mult completes, start div in the first busy=0 cycle -> accepted; busy=1 the next cycle with no gap.
- Reset asserted on the 4th busy cycle of a div that follows mthi 0xAAAA -> next cycle busy=0, hi=0, lo=0, no later commit.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// Shared multiply/divide op codes and sizing helpers for the E-stage MDU.
package e_mdu_pkg;

    // 4-bit MD operation code carried in the E-stage control bundle.
    typedef enum logic [3:0] {
        MdOpNone  = 4'd0,
        MdOpMult  = 4'd1,
        MdOpMultu = 4'd2,
        MdOpDiv   = 4'd3,
        MdOpDivu  = 4'd4,
        MdOpMthi  = 4'd5,
        MdOpMtlo  = 4'd6,
        MdOpMfhi  = 4'd7,
        MdOpMflo  = 4'd8
    } md_op_e;

    // Sequencer states: IDLE accepts work, RUN counts down the fixed latency.
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    // Larger of two cycle counts, used to size the latency counter.
    function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/e_md_calc.sv
// Combinational 32x32 multiply and divide datapath with signed/unsigned select.
module e_md_calc (
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] prod_o,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o,
    output logic        div_zero_o
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Sign-extend when signed so the low 64 bits of one multiply serve both flavours.
    always_comb begin
        a_ext  = {{32{a_i[31] & signed_i}}, a_i};
        b_ext  = {{32{b_i[31] & signed_i}}, b_i};
        prod_o = a_ext * b_ext;
    end

    // Divide on magnitudes, then restore signs: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000, rem 0.
    always_comb begin
        a_neg      = signed_i & a_i[31];
        b_neg      = signed_i & b_i[31];
        a_mag      = a_neg ? (~a_i + 32'd1) : a_i;
        b_mag      = b_neg ? (~b_i + 32'd1) : b_i;
        div_zero_o = (b_i == 32'd0);
        if (div_zero_o) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot_o = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem_o  = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide sequencer: owns HI/LO and enforces fixed MD latency.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdResult
);

    localparam int unsigned MaxCycles = max_cycles(MULT_CYCLES, DIV_CYCLES);
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);

    md_op_e      op;
    logic        op_signed;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    md_state_e   state_q;
    logic [CntW-1:0] cnt_q;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] pend_hi_q;
    logic [31:0] pend_lo_q;
    logic        pend_we_q;  // low when a divide-by-zero must leave HI/LO untouched

    assign op        = md_op_e'(mdOp);
    assign op_signed = (op == MdOpMult) || (op == MdOpDiv);

    e_md_calc u_calc (
        .signed_i   (op_signed),
        .a_i        (srcA),
        .b_i        (srcB),
        .prod_o     (prod),
        .quot_o     (quot),
        .rem_o      (rem),
        .div_zero_o (div_zero)
    );

    // Sequencer: accept ops in IDLE, count down in RUN and commit pending results on the last edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        unique case (op)
                            MdOpMult, MdOpMultu: begin
                                pend_hi_q <= prod[63:32];
                                pend_lo_q <= prod[31:0];
                                pend_we_q <= 1'b1;
                                cnt_q     <= MultCnt;
                                busy_q    <= 1'b1;
                                state_q   <= StRun;
                            end
                            MdOpDiv, MdOpDivu: begin
                                pend_hi_q <= rem;
                                pend_lo_q <= quot;
                                pend_we_q <= ~div_zero;
                                cnt_q     <= DivCnt;
                                busy_q    <= 1'b1;
                                state_q   <= StRun;
                            end
                            MdOpMthi: hi_q <= srcA;
                            MdOpMtlo: lo_q <= srcA;
                            default: ;
                        endcase
                    end
                end
                StRun: begin
                    // Any start here is dropped; the hazard unit should never issue one.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntW'(1)) begin
                        if (pend_we_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Move-from read port: no forwarding of pending results, the hazard unit stalls instead.
    always_comb begin
        mdResult = 32'd0;
        unique case (op)
            MdOpMfhi: mdResult = hi_q;
            MdOpMflo: mdResult = lo_q;
            default:  mdResult = 32'd0;
        endcase
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
